// File: rtl/hazard_forward_unit.sv
// Purpose : tracks in-flight destination tags; drives EX operand-forward selects and load-use stall/bubble.
// Latency : controls are combinational from the tags; the tags advance one stage per non-hold clock.
// Backpr. : hold freezes all tags; stall asks upstream to hold PC and IF/ID; flush/stall/invalid bubble ID/EX.
//
// Ports:
//   clk, rst (async, active-high), hold, flush
//   ifIdValid, ifIdRs, ifIdRt, ifIdRd, ifIdRegWrite, ifIdMemRead : decode-stage fields
//   operand1Control / operand2Control : 0 = regfile, k = result of tracked stage k
//   stall      : hold PC and IF/ID this cycle
//   idExBubble : ID/EX is being loaded with a bubble this cycle
//   stallCount, fwdCount : saturating statistics, present only when HAZARD_STATS_EN is defined
module hazard_forward_unit #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_STALL = 1,
  parameter int CTRL_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              flush,
  input  logic              ifIdValid,
  input  logic [REG_AW-1:0] ifIdRs,
  input  logic [REG_AW-1:0] ifIdRt,
  input  logic [REG_AW-1:0] ifIdRd,
  input  logic              ifIdRegWrite,
  input  logic              ifIdMemRead,
  output logic [CTRL_W-1:0] operand1Control,
  output logic [CTRL_W-1:0] operand2Control,
  output logic              stall,
  output logic              idExBubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]       stallCount,
  output logic [15:0]       fwdCount
`endif
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } tag_t;

  logic [REG_AW-1:0] idex_rs_q, idex_rs_d;
  logic [REG_AW-1:0] idex_rt_q, idex_rt_d;
  tag_t              idex_q, idex_d;
  tag_t              stg_q [1:FWD_STAGES];
  tag_t              stg_d [1:FWD_STAGES];

  logic load_hit;
  logic insert_bubble;

  // Forwarding: scan farthest to nearest so the nearest producer overwrites.
  always_comb begin
    operand1Control = '0;
    operand2Control = '0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (stg_q[k].wr && stg_q[k].rd != '0) begin
        if (stg_q[k].rd == idex_rs_q) operand1Control = CTRL_W'(k);
        if (stg_q[k].rd == idex_rt_q) operand2Control = CTRL_W'(k);
      end
    end
  end

  // Load-use: a load still in ID/EX or stages 1..LOAD_STALL-1 cannot reach the consumer in time.
  always_comb begin
    load_hit = 1'b0;
    if (LOAD_STALL > 0) begin
      if (idex_q.ld && idex_q.wr && idex_q.rd != '0 &&
          (idex_q.rd == ifIdRs || idex_q.rd == ifIdRt))
        load_hit = 1'b1;
    end
    for (int j = 1; j < LOAD_STALL; j++) begin
      if (stg_q[j].ld && stg_q[j].wr && stg_q[j].rd != '0 &&
          (stg_q[j].rd == ifIdRs || stg_q[j].rd == ifIdRt))
        load_hit = 1'b1;
    end
  end

  assign stall         = ifIdValid && !flush && load_hit;
  assign insert_bubble = stall || flush || !ifIdValid;
  // Reset is reported as a quiet pipeline, not a bubble insertion.
  assign idExBubble    = !rst && !hold && insert_bubble;

  always_comb begin
    idex_rs_d = idex_rs_q;
    idex_rt_d = idex_rt_q;
    idex_d    = idex_q;
    for (int k = 1; k <= FWD_STAGES; k++) stg_d[k] = stg_q[k];
    if (!hold) begin
      // Older tags always drain, even on flush: those instructions are committed.
      stg_d[1] = idex_q;
      for (int k = 2; k <= FWD_STAGES; k++) stg_d[k] = stg_q[k-1];
      if (insert_bubble) begin
        idex_rs_d = '0;
        idex_rt_d = '0;
        idex_d    = '0;
      end else begin
        idex_rs_d = ifIdRs;
        idex_rt_d = ifIdRt;
        idex_d    = '{rd: ifIdRd, wr: ifIdRegWrite, ld: ifIdMemRead};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_rs_q <= '0;
      idex_rt_q <= '0;
      idex_q    <= '0;
      for (int k = 1; k <= FWD_STAGES; k++) stg_q[k] <= '0;
    end else begin
      idex_rs_q <= idex_rs_d;
      idex_rt_q <= idex_rt_d;
      idex_q    <= idex_d;
      for (int k = 1; k <= FWD_STAGES; k++) stg_q[k] <= stg_d[k];
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] fwd_cnt_q, fwd_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (!hold) begin
      if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      // One count per cycle even when both operands are forwarded.
      if ((operand1Control != '0 || operand2Control != '0) && fwd_cnt_q != 16'hFFFF)
        fwd_cnt_d = fwd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stallCount = stall_cnt_q;
  assign fwdCount   = fwd_cnt_q;
`endif

endmodule
